// File: rtl/vend_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vend_pkg -- controller states, coin values and coin-priority helpers.  Rev 1.0
// -----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    PAYOUT  = 2'd3
  } vend_state_t;

  localparam logic [5:0] NICKEL_CENTS  = 6'd5;
  localparam logic [5:0] DIME_CENTS    = 6'd10;
  localparam logic [5:0] QUARTER_CENTS = 6'd25;

  // Only the most valuable coin of a cycle is credited.
  function automatic logic [5:0] coin_value(input logic nickel, input logic dime,
                                            input logic quarter);
    if (quarter)     return QUARTER_CENTS;
    else if (dime)   return DIME_CENTS;
    else if (nickel) return NICKEL_CENTS;
    else             return 6'd0;
  endfunction

  function automatic logic coin_overlap(input logic nickel, input logic dime,
                                        input logic quarter);
    return (quarter & (dime | nickel)) | (dime & nickel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/credit_acc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// credit_acc -- credit register with add/subtract datapath; clamps at zero.  Rev 1.0
// -----------------------------------------------------------------------------
module credit_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] add_amt,
  input  logic [5:0] sub_amt,
  output logic [5:0] credit,
  output logic [5:0] credit_nxt
);

  logic [6:0] sum;
  logic [6:0] diff;

  assign sum        = {1'b0, credit} + {1'b0, add_amt};
  assign diff       = sum - {1'b0, sub_amt};
  assign credit_nxt = (sum >= {1'b0, sub_amt}) ? diff[5:0] : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit <= 6'd0;
    else        credit <= credit_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/vend_seq_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vend_seq_ctrl -- coin collection, soda vend handshake and change payout FSM.  Rev 1.0
// -----------------------------------------------------------------------------
module vend_seq_ctrl #(
  parameter int PRICE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       disp_ack,
  input  logic       hop_ack,
  output logic       soda_req,
  output logic       nickel_out,
  output logic       dime_out,
  output logic [5:0] credit,
  output logic       busy,
  output logic       coin_rej
);
  import vend_pkg::*;

  localparam logic [5:0] PRICE_CENTS = 6'(PRICE);

  vend_state_t state, state_nxt;
  logic        gap, gap_nxt;
  logic        rej_nxt;
  logic        any_coin, collecting, paying, hop_take;
  logic [5:0]  coin_val, change_coin, add_amt, sub_amt, credit_nxt;

  assign coin_val    = coin_value(nickel, dime, quarter);
  assign any_coin    = nickel | dime | quarter;
  assign collecting  = (state == IDLE) || (state == COLLECT);
  // gap marks the mandatory idle cycle after each hopper handshake
  assign paying      = (state == PAYOUT) && !gap;
  assign change_coin = (credit >= DIME_CENTS) ? DIME_CENTS : NICKEL_CENTS;
  assign hop_take    = paying && hop_ack;
  assign add_amt     = collecting ? coin_val : 6'd0;
  assign sub_amt     = ((state == VEND) && disp_ack) ? PRICE_CENTS :
                       hop_take                      ? change_coin : 6'd0;

  credit_acc u_credit_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_amt    (add_amt),
    .sub_amt    (sub_amt),
    .credit     (credit),
    .credit_nxt (credit_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gap      <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap      <= gap_nxt;
      coin_rej <= rej_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gap_nxt    = 1'b0;
    rej_nxt    = any_coin;
    soda_req   = 1'b0;
    dime_out   = 1'b0;
    nickel_out = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        rej_nxt = coin_overlap(nickel, dime, quarter);
        if (credit_nxt >= PRICE_CENTS) state_nxt = VEND;
        else if (credit_nxt != 6'd0)   state_nxt = COLLECT;
      end
      VEND: begin
        soda_req = 1'b1;
        busy     = 1'b1;
        if (disp_ack) state_nxt = (credit_nxt != 6'd0) ? PAYOUT : IDLE;
      end
      PAYOUT: begin
        busy       = 1'b1;
        dime_out   = paying && (credit >= DIME_CENTS);
        nickel_out = paying && (credit < DIME_CENTS);
        if (hop_take) begin
          gap_nxt = 1'b1;
          if (credit_nxt == 6'd0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_seq_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vend_seq_ctrl -- directed and randomized checks against a credit/change-queue model.  Rev 1.0
// -----------------------------------------------------------------------------
module tb_vend_seq_ctrl;

  localparam int PRICE = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nickel, dime, quarter, disp_ack, hop_ack;
  logic       soda_req, nickel_out, dime_out, busy, coin_rej;
  logic [5:0] credit;

  int checks = 0;
  int errors = 0;

  // Reference model: credit total, a vend-pending flag and the list of change coins owed.
  int m_credit;
  bit m_vend;
  bit m_gap;
  bit m_rej;
  int chg[$];

  always #5 clk = ~clk;

  vend_seq_ctrl #(.PRICE(PRICE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nickel     (nickel),
    .dime       (dime),
    .quarter    (quarter),
    .disp_ack   (disp_ack),
    .hop_ack    (hop_ack),
    .soda_req   (soda_req),
    .nickel_out (nickel_out),
    .dime_out   (dime_out),
    .credit     (credit),
    .busy       (busy),
    .coin_rej   (coin_rej)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_gap    = 0;
    m_rej    = 0;
    chg.delete();
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input bit da, input bit ha);
    int rem;
    if (m_vend || chg.size() > 0) begin
      m_rej = n | d | q;
      if (m_vend) begin
        if (da) begin
          m_vend   = 0;
          rem      = m_credit - PRICE;
          m_credit = rem;
          m_gap    = 0;
          chg.delete();
          while (rem >= 10) begin chg.push_back(10); rem -= 10; end
          if (rem > 0) chg.push_back(5);
        end
      end else if (!m_gap && ha) begin
        m_credit -= chg.pop_front();
        m_gap = 1;
      end else begin
        m_gap = 0;
      end
    end else begin
      m_rej    = (int'(n) + int'(d) + int'(q)) > 1;
      m_credit += q ? 25 : d ? 10 : n ? 5 : 0;
      if (m_credit >= PRICE) m_vend = 1;
    end
  endtask

  task automatic check_outputs();
    bit pay;
    int head;
    pay  = !m_vend && chg.size() > 0 && !m_gap;
    head = (chg.size() > 0) ? chg[0] : 0;
    check("credit",     32'(credit),     32'(m_credit));
    check("soda_req",   32'(soda_req),   32'(m_vend));
    check("dime_out",   32'(dime_out),   32'(pay && head == 10));
    check("nickel_out", 32'(nickel_out), 32'(pay && head == 5));
    check("busy",       32'(busy),       32'(m_vend || chg.size() > 0));
    check("coin_rej",   32'(coin_rej),   32'(m_rej));
  endtask

  // Drive one cycle of inputs (from a negedge), advance one clock, compare at the next negedge.
  task automatic step(input bit n, input bit d, input bit q, input bit da, input bit ha);
    nickel = n; dime = d; quarter = q; disp_ack = da; hop_ack = ha;
    model_step(n, d, q, da, ha);
    @(posedge clk);
    @(negedge clk);
    nickel = 0; dime = 0; quarter = 0; disp_ack = 0; hop_ack = 0;
    check_outputs();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      step(0, 0, 0, 1, 1);
      k++;
    end
    check("drain_done", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_outs",   32'({soda_req, nickel_out, dime_out, busy, coin_rej}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    nickel = 0; dime = 0; quarter = 0; disp_ack = 0; hop_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Four nickels, dispenser answers after two cycles, no change owed.
    repeat (4) step(1, 0, 0, 0, 0);
    check("n4_credit", 32'(credit), 32'd20);
    check("n4_soda",   32'(soda_req), 32'd1);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("n4_after", 32'({soda_req, busy, credit}), 32'd0);

    // Dime + quarter: 35 cents, 15 back as one dime then one nickel.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("dq_credit", 32'(credit), 32'd35);
    step(0, 0, 0, 1, 0);
    check("dq_change", 32'(credit), 32'd15);
    check("dq_dime",   32'(dime_out), 32'd1);
    step(0, 0, 0, 0, 1);
    check("dq_gap",    32'({dime_out, nickel_out}), 32'd0);
    step(0, 0, 0, 0, 0);
    check("dq_nickel", 32'(nickel_out), 32'd1);
    step(0, 0, 0, 0, 1);
    check("dq_done",   32'({busy, credit}), 32'd0);

    // Nickel, dime, quarter: 40 cents, two dimes with a gap between handshakes.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("ndq_credit", 32'(credit), 32'd40);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("ndq_gap_ack", 32'(credit), 32'd10);
    step(0, 0, 0, 0, 1);
    check("ndq_done", 32'({busy, credit}), 32'd0);

    // Simultaneous dime + nickel, then a quarter pushed in while vending.
    step(1, 1, 0, 0, 0);
    check("dn_credit", 32'(credit), 32'd10);
    check("dn_rej",    32'(coin_rej), 32'd1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("qv_rej",    32'(coin_rej), 32'd1);
    check("qv_credit", 32'(credit), 32'd35);
    drain();

    // Reset while a dime is being requested; a late hopper ack is ignored.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    check("rp_dime", 32'(dime_out), 32'd1);
    do_reset();
    step(0, 0, 0, 0, 1);
    check("rp_ignored", 32'(credit), 32'd0);

    // Randomized traffic, including spurious acks and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
